// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared defaults and pointer helpers for the async FIFO slice.
//   D_SIZE_DEF  : default data width in bits
//   F_DEPTH_DEF : default number of FIFO entries (power of two)
//   P_SIZE_DEF  : default pointer width, log2(F_DEPTH_DEF)+1
//   bin2gray / gray2bin operate on a zero-extended 32-bit value so any
//   pointer width up to 32 bits can use them; callers truncate the result.
package fifo_pkg;

  localparam int D_SIZE_DEF  = 16;
  localparam int F_DEPTH_DEF = 8;
  localparam int P_SIZE_DEF  = 4;
  localparam int PTR_EXT_W   = 32;

  typedef logic [PTR_EXT_W-1:0] ptr_ext_t;

  function automatic ptr_ext_t bin2gray(input ptr_ext_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits decode to zero, so the MSB-first prefix XOR
  // gives the correct binary value for the narrow pointer.
  function automatic ptr_ext_t gray2bin(input ptr_ext_t g);
    ptr_ext_t b;
    b[PTR_EXT_W-1] = g[PTR_EXT_W-1];
    for (int i = PTR_EXT_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// sync_w2r -- two-flop synchronizer bringing the write-domain Gray pointer
// into the read clock domain.
//   r_clk    : read-domain clock
//   r_rst    : synchronous active-high reset, clears both stages
//   w_gptr   : Gray-coded write pointer, asynchronous to r_clk
//   wq2_gptr : synchronized pointer, two r_clk cycles of latency
module sync_w2r
  import fifo_pkg::*;
#(
  parameter int WIDTH = P_SIZE_DEF
) (
  input  logic             r_clk,
  input  logic             r_rst,
  input  logic [WIDTH-1:0] w_gptr,
  output logic [WIDTH-1:0] wq2_gptr
);

  logic [WIDTH-1:0] wq1_gptr;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      wq1_gptr <= '0;
      wq2_gptr <= '0;
    end else begin
      wq1_gptr <= w_gptr;
      wq2_gptr <= wq1_gptr;
    end
  end

endmodule

// File: rtl/fifo_mem_read.sv
// fifo_mem_read -- read side of an asynchronous FIFO with a one-word
// registered output stage and valid/ready handshake.
//   r_clk    : read-domain clock
//   r_rst    : synchronous active-high reset
//   FIFO_MEM : storage array written by the write side
//   w_gptr   : Gray write pointer from the write domain (unsynchronized)
//   r_ready  : consumer accepts r_data this cycle
//   r_data   : output word
//   r_valid  : r_data holds an unconsumed entry
//   r_addr   : current read address into FIFO_MEM
//   r_gptr   : registered Gray read pointer for the write side
//   r_empty  : no entries left in storage that have not been fetched
//   r_level  : number of entries in storage not yet fetched
module fifo_mem_read
  import fifo_pkg::*;
#(
  parameter int D_SIZE  = D_SIZE_DEF,
  parameter int F_DEPTH = F_DEPTH_DEF,
  parameter int P_SIZE  = P_SIZE_DEF
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic [D_SIZE-1:0] FIFO_MEM [F_DEPTH],
  input  logic [P_SIZE-1:0] w_gptr,
  input  logic              r_ready,
  output logic [D_SIZE-1:0] r_data,
  output logic              r_valid,
  output logic [P_SIZE-2:0] r_addr,
  output logic [P_SIZE-1:0] r_gptr,
  output logic              r_empty,
  output logic [P_SIZE-1:0] r_level
);

  logic [P_SIZE-1:0] wq2_gptr;
  logic [P_SIZE-1:0] r_bin;
  logic [P_SIZE-1:0] next_bin;
  logic [P_SIZE-1:0] next_gray;
  logic [P_SIZE-1:0] wq2_bin;
  logic              pop;

  sync_w2r #(
    .WIDTH (P_SIZE)
  ) u_sync_w2r (
    .r_clk    (r_clk),
    .r_rst    (r_rst),
    .w_gptr   (w_gptr),
    .wq2_gptr (wq2_gptr)
  );

  assign r_addr = r_bin[P_SIZE-2:0];

  // Refill the output stage when it is idle or being consumed this cycle.
  // r_empty already accounts for the previous pop, so this never underflows.
  always_comb begin
    pop       = !r_empty && (!r_valid || r_ready);
    next_bin  = r_bin + P_SIZE'(pop);
    next_gray = P_SIZE'(bin2gray(PTR_EXT_W'(next_bin)));
    wq2_bin   = P_SIZE'(gray2bin(PTR_EXT_W'(wq2_gptr)));
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_bin   <= '0;
      r_gptr  <= '0;
      r_level <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (pop) begin
        r_data <= FIFO_MEM[r_addr];
      end
      r_bin   <= next_bin;
      r_valid <= pop || (r_valid && !r_ready);
      r_gptr  <= next_gray;
      r_empty <= (next_gray == wq2_gptr);
      r_level <= wq2_bin - next_bin;
    end
  end

endmodule
